// File: rtl/dual_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : dual_shift_unit
// Description : Two WIDTH-bit shift registers (A, B) plus a sequencer. An
//               Execute request runs SHIFT_CNT shifts of both registers in a
//               latched direction and serial-source mode, then reports Done.
//               While no run is active, each register can be cleared or
//               parallel loaded, with clear taking priority over load.
// Ports       : Clk, Reset (sync, active-high)
//               Clr_A/Clr_B, Ld_A/Ld_B, DA/DB  - clear / parallel load (idle only)
//               Execute, Dir, Mode             - run request, direction, serial source
//               A_In/B_In                      - external serial inputs (Mode 00/11)
//               A_out/B_out                    - bit currently leaving A / B
//               A, B                           - register contents
//               Busy, Done                     - SHIFT / DONE state indicators
//               A_zero/B_zero                  - registered all-zero flags
//                                                (only with DSU_ZERO_FLAG_EN)
// Options     : `define DSU_ZERO_FLAG_EN to add A_zero / B_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_shift_unit #(
    parameter int WIDTH     = 8,
    parameter int SHIFT_CNT = WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr_A,
    input  logic             Clr_B,
    input  logic             Ld_A,
    input  logic             Ld_B,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    input  logic             Execute,
    input  logic             Dir,
    input  logic [1:0]       Mode,
    input  logic             A_In,
    input  logic             B_In,
    output logic             A_out,
    output logic             B_out,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
`ifdef DSU_ZERO_FLAG_EN
    output logic             A_zero,
    output logic             B_zero,
`endif
    output logic             Done
);

    // Counter holds 0..SHIFT_CNT-1 (index of the shift being performed).
    localparam int                 c_CNT_W = (SHIFT_CNT > 1) ? $clog2(SHIFT_CNT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SHIFT_CNT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic               w_shifting;
    logic               w_start;
    logic               w_dir_eff;
    logic               w_a_out;
    logic               w_b_out;
    logic               w_a_ser;
    logic               w_b_ser;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_b_next;

    assign w_shifting = (r_state == c_ST_SHIFT);
    assign w_start    = (r_state == c_ST_IDLE) && Execute;

    // During a run the outgoing bit follows the latched direction; otherwise
    // it tracks the live Dir input so the caller can preview the next bit.
    assign w_dir_eff = w_shifting ? r_dir : Dir;
    assign w_a_out   = w_dir_eff ? r_a[WIDTH-1] : r_a[0];
    assign w_b_out   = w_dir_eff ? r_b[WIDTH-1] : r_b[0];

    // Serial source selection. Cross mode uses the pre-shift outgoing bits,
    // so A and B effectively swap contents after WIDTH shifts.
    always_comb begin
        w_a_ser = A_In;
        w_b_ser = B_In;
        case (r_mode)
            2'b01: begin
                w_a_ser = w_a_out;
                w_b_ser = w_b_out;
            end
            2'b10: begin
                w_a_ser = w_b_out;
                w_b_ser = w_a_out;
            end
            default: begin
                w_a_ser = A_In;
                w_b_ser = B_In;
            end
        endcase
    end

    // Register next values: shift during a run, else Clr > Ld > hold.
    always_comb begin
        w_a_next = r_a;
        w_b_next = r_b;
        if (w_shifting) begin
            w_a_next = r_dir ? {r_a[WIDTH-2:0], w_a_ser} : {w_a_ser, r_a[WIDTH-1:1]};
            w_b_next = r_dir ? {r_b[WIDTH-2:0], w_b_ser} : {w_b_ser, r_b[WIDTH-1:1]};
        end else begin
            if (Clr_A)     w_a_next = '0;
            else if (Ld_A) w_a_next = DA;
            if (Clr_B)     w_b_next = '0;
            else if (Ld_B) w_b_next = DB;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (Execute) w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: if (r_count == c_LAST) w_next_state = c_ST_DONE;
            c_ST_DONE:  if (!Execute) w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 2'b00;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_next_state;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            if (w_start) begin
                r_dir   <= Dir;
                r_mode  <= Mode;
                r_count <= '0;
            end else if (w_shifting) begin
                r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
            end
        end
    end

`ifdef DSU_ZERO_FLAG_EN
    // Flags are computed from the next register values so they line up
    // with the registers themselves every cycle.
    logic r_a_zero;
    logic r_b_zero;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a_zero <= 1'b1;
            r_b_zero <= 1'b1;
        end else begin
            r_a_zero <= (w_a_next == '0);
            r_b_zero <= (w_b_next == '0);
        end
    end

    assign A_zero = r_a_zero;
    assign B_zero = r_b_zero;
`endif

    assign A_out = w_a_out;
    assign B_out = w_b_out;
    assign A     = r_a;
    assign B     = r_b;
    assign Busy  = w_shifting;
    assign Done  = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
